// File: rtl/mips_avalon_pkg.sv
// Shared Avalon-MM types and response codes for the MIPS arbiter and slave.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/mips_avalon_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with registered grants and a per-grant watchdog.
// Optional ARB_ROUND_ROBIN_EN: ties alternate ownership; otherwise M0 wins every tie.
module mips_avalon_arbiter
  import mips_avalon_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic [1:0]          m0_response,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [1:0]          m1_response,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic [1:0]          s_response,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout_err_q, timeout_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic req0, req1, own0, own1, owned, own_req, tmo_c;

  // Ownership decode and watchdog expiry for the current cycle
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    own0    = (state_q == OWN0);
    own1    = (state_q == OWN1);
    owned   = own0 | own1;
    own_req = own1 ? req1 : req0;
    tmo_c   = owned && (wdog_q == WD_W'(TIMEOUT));
  end

  // Next-state, last-owner and watchdog logic
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q | tmo_c;
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_q ? OWN0 : OWN1;
`else
          state_d = OWN0;
`endif
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (tmo_c || !own_req) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
          last_d  = own1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == OWN1, state_d == OWN0};
  end

  // Owner-to-slave mux; an idle or expiring slave port keeps the last address/data
  always_comb begin
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_address    = addr_q;
    s_byteenable = be_q;
    s_writedata  = wdata_q;
    if (owned && !tmo_c) begin
      s_read       = own1 ? m1_read : m0_read;
      s_write      = own1 ? (m1_write & ~m1_read) : (m0_write & ~m0_read);
      s_address    = own1 ? m1_address : m0_address;
      s_byteenable = own1 ? m1_byteenable : m0_byteenable;
      s_writedata  = own1 ? m1_writedata : m0_writedata;
    end
    addr_d  = s_address;
    be_d    = s_byteenable;
    wdata_d = s_writedata;
  end

  // Slave-to-master return path; the expiry cycle terminates the owner with SLVERR
  always_comb begin
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m0_response    = RESP_OKAY;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    m1_response    = RESP_OKAY;
    if (own0) begin
      m0_waitrequest = tmo_c ? 1'b0 : s_waitrequest;
      m0_readdata    = tmo_c ? '0 : s_readdata;
      m0_response    = tmo_c ? RESP_SLVERR : s_response;
    end
    if (own1) begin
      m1_waitrequest = tmo_c ? 1'b0 : s_waitrequest;
      m1_readdata    = tmo_c ? '0 : s_readdata;
      m1_response    = tmo_c ? RESP_SLVERR : s_response;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
    end
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed self-checking bench for mips_avalon_arbiter (TIMEOUT=8); grant bit N marks master N.
module tb_mips_avalon_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk, reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic              m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic [1:0]        m0_response, m1_response, s_response;
  logic [1:0]        grant;
  logic              timeout_err;

  int errors = 0;
  int checks = 0;

  mips_avalon_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_response(m0_response),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_response(m1_response),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_response(s_response),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_response = 2'b00;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, timeout_err, m0_waitrequest, m1_waitrequest, s_read, s_write} !== 7'b00_0_11_00) begin
      errors++;
      $display("FAIL reset_state: got grant=%b terr=%b w0=%b w1=%b sr=%b sw=%b want 00 0 1 1 0 0",
               grant, timeout_err, m0_waitrequest, m1_waitrequest, s_read, s_write);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_transfer();
    @(negedge clk);
    m1_write = 1'b1; m1_address = 32'h0000_0040; m1_writedata = 32'h1234_5678;
    m1_byteenable = 4'hF; s_waitrequest = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || s_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_own1: got grant=%b s_write=%b want 10 1", grant, s_write);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, s_write, m1_waitrequest} !== 4'b00_0_1) begin
      errors++;
      $display("FAIL async_abort: got grant=%b s_write=%b w1=%b want 00 0 1",
               grant, s_write, m1_waitrequest);
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_m1_read();
    @(negedge clk);
    m1_read = 1'b1; m1_address = 32'hBFC0_0000; m1_byteenable = 4'hF; s_waitrequest = 1'b1;
    #1;
    checks++;
    if ({grant, s_read, m1_waitrequest} !== 4'b00_0_1) begin
      errors++;
      $display("FAIL read_latency: got grant=%b s_read=%b w1=%b want 00 0 1",
               grant, s_read, m1_waitrequest);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || s_read !== 1'b1 || s_address !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL read_grant: got grant=%b s_read=%b addr=%h want 10 1 bfc00000",
               grant, s_read, s_address);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || m1_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL read_wait%0d: got grant=%b w1=%b want 10 1", k, grant, m1_waitrequest);
      end
    end
    @(negedge clk);
    s_waitrequest = 1'b0; s_readdata = 32'h2402_0005; s_response = 2'b00;
    #1;
    checks++;
    if (m1_waitrequest !== 1'b0 || m1_readdata !== 32'h2402_0005 || m0_readdata !== 32'h0) begin
      errors++;
      $display("FAIL read_done: got w1=%b rd1=%h rd0=%h want 0 24020005 00000000",
               m1_waitrequest, m1_readdata, m0_readdata);
    end
    @(negedge clk);
    m1_read = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || s_read !== 1'b0 || s_address !== 32'hBFC0_0000 || m1_readdata !== 32'h0) begin
      errors++;
      $display("FAIL read_release: got grant=%b s_read=%b addr=%h rd1=%h want 00 0 bfc00000 0",
               grant, s_read, s_address, m1_readdata);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    reset_pulse();
    @(negedge clk);
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 32'h10; m1_address = 32'h20;
    s_waitrequest = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      if (k % 2 == 0) begin
        exp = 2'b00;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        exp = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
`else
        exp = 2'b01;
`endif
      end
      #1;
      checks++;
      if (grant !== exp) begin
        errors++;
        $display("FAIL arb_cycle%0d: got grant=%b want %b", k, grant, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m0_read = 1'b1; m0_address = 32'h0000_0100; m0_byteenable = 4'hF;
    s_waitrequest = 1'b1; s_response = 2'b00; s_readdata = 32'h5555_AAAA;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({m0_waitrequest, s_read, m0_response, grant} !== 6'b1_1_00_01) begin
        errors++;
        $display("FAIL stall%0d: got w0=%b s_read=%b resp=%b grant=%b want 1 1 00 01",
                 k, m0_waitrequest, s_read, m0_response, grant);
      end
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL terr_early: got %b want 0", timeout_err);
    end
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, m0_response, s_read} !== 4'b0_10_0) begin
      errors++;
      $display("FAIL tmo_release: got w0=%b resp=%b s_read=%b want 0 10 0",
               m0_waitrequest, m0_response, s_read);
    end
    @(negedge clk);
    m0_read = 1'b0; s_waitrequest = 1'b0;
    checks++;
    if ({grant, timeout_err, m0_response, m0_waitrequest} !== 6'b00_1_00_1) begin
      errors++;
      $display("FAIL tmo_after: got grant=%b terr=%b resp=%b w0=%b want 00 1 00 1",
               grant, timeout_err, m0_response, m0_waitrequest);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL terr_sticky: got %b want 1", timeout_err);
    end
  endtask

  task automatic test_m0_write();
    @(negedge clk);
    m0_write = 1'b1; m0_address = 32'h0000_1000; m0_byteenable = 4'b0011;
    m0_writedata = 32'hDEAD_BEEF; s_waitrequest = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_write, s_read} !== 2'b10 || s_address !== 32'h0000_1000 ||
        s_byteenable !== 4'b0011 || s_writedata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_fields: got sw=%b sr=%b addr=%h be=%b wd=%h want 1 0 00001000 0011 deadbeef",
               s_write, s_read, s_address, s_byteenable, s_writedata);
    end
    checks++;
    if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL write_stall: got w0=%b w1=%b want 1 1", m0_waitrequest, m1_waitrequest);
    end
    @(negedge clk);
    s_waitrequest = 1'b0;
    #1;
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL write_done: got w0=%b w1=%b want 0 1", m0_waitrequest, m1_waitrequest);
    end
    @(negedge clk);
    m0_write = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || s_write !== 1'b0 || s_writedata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_idle: got grant=%b sw=%b wd=%h want 00 0 deadbeef",
               grant, s_write, s_writedata);
    end
  endtask

  task automatic test_req_drop();
    logic [1:0] exp;
    reset_pulse();
    @(negedge clk);
    m0_read = 1'b1; s_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || m0_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL drop_m0xfer: got grant=%b w0=%b want 01 0", grant, m0_waitrequest);
    end
    @(negedge clk);
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 32'h0000_0200; s_waitrequest = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || m1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant: got grant=%b w1=%b want 10 1", grant, m1_waitrequest);
    end
    @(negedge clk);
    m1_read = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: got grant=%b terr=%b want 00 0", grant, timeout_err);
    end
    m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp = 2'b10;
`else
    exp = 2'b01;
`endif
    checks++;
    if (grant !== exp) begin
      errors++;
      $display("FAIL drop_last: got grant=%b want %b", grant, exp);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 2'b00 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_final: got grant=%b terr=%b want 00 0", grant, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_transfer();
    test_m1_read();
    test_arbitration();
    test_timeout();
    test_m0_write();
    test_req_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
